// File: rtl/fpu_pkg.sv
// fpu_pkg: scalar float types shared across the FPU.
// Holds the canonical NaN pattern and rounding-mode encoding.
package fpu_pkg;

  typedef logic [31:0] fpu_float_t;

  typedef enum logic [1:0] {
    FPU_RM_RNE = 2'd0,
    FPU_RM_RTZ = 2'd1,
    FPU_RM_RDN = 2'd2,
    FPU_RM_RUP = 2'd3
  } fpu_round_mode_t;

  localparam fpu_float_t FPU_FLOAT_NAN = 32'hFFFF_FFFF;

endpackage

// File: rtl/fpu_unit_arbiter_pkg.sv
// fpu_unit_arbiter_pkg: types for the shared-unit arbiter.
// Opcode, FSM state, IEEE flag bundle and NaN helper.
package fpu_unit_arbiter_pkg;
  import fpu_pkg::*;

  typedef enum logic [2:0] {
    DIV  = 3'd0,
    SQRT = 3'd1,
    FMA  = 3'd2,
    REM  = 3'd3
  } fpu_arb_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } fpu_arb_state_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_arb_flags_t;

  localparam fpu_arb_flags_t FPU_ARB_FLAGS_INVALID = 5'b10000;

  function automatic logic is_nan(fpu_float_t x);
    return x == FPU_FLOAT_NAN;
  endfunction

endpackage

// File: rtl/fpu_rr_picker.sv
// fpu_rr_picker: round-robin first-one finder.
// Scans req upward from rr_ptr, wrapping modulo NUM_REQ.
module fpu_rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    rr_ptr,
  output logic [IDXW-1:0]    winner,
  output logic               any_valid
);

  function automatic logic [IDXW-1:0] wrap_idx(
    logic [IDXW-1:0] p,
    int              off
  );
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDXW'(s);
  endfunction

  assign any_valid = |req;

  // Nearest set bit at or after rr_ptr wins
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap_idx(rr_ptr, i)]) winner = wrap_idx(rr_ptr, i);
    end
  end

endmodule

// File: rtl/fpu_unit_arbiter.sv
// fpu_unit_arbiter: round-robin share of one iterative FPU unit.
// Optional watchdog on unit response: FPU_UNIT_ARBITER_TIMEOUT_EN.
module fpu_unit_arbiter
  import fpu_pkg::*;
  import fpu_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*3-1:0]  req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]  req_mode,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_result,
  output logic [4:0]            resp_flags,
  output logic                  unit_req_valid,
  input  logic                  unit_req_ready,
  output logic [2:0]            unit_op,
  output logic [31:0]           unit_a,
  output logic [31:0]           unit_b,
  output logic [1:0]            unit_mode,
  input  logic                  unit_resp_valid,
  output logic                  unit_resp_ready,
  input  logic [31:0]           unit_result,
  input  logic [4:0]            unit_flags,
`ifdef FPU_UNIT_ARBITER_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  busy
);

  localparam int IDXW = $clog2(NUM_REQ);

  fpu_arb_state_t  state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] grant;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] ptr_next;
  logic            any_valid;
  fpu_arb_op_t     op_q;
  fpu_float_t      a_q;
  fpu_float_t      b_q;
  fpu_round_mode_t mode_q;
  fpu_float_t      res_q;
  fpu_arb_flags_t  flags_q;
  fpu_float_t      win_a;
  fpu_float_t      win_b;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic            drain;
  logic            timed_out;

  fpu_rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  assign win_a = req_a[winner*32 +: 32];
  assign win_b = req_b[winner*32 +: 32];

  assign ptr_next = (grant == IDXW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  // One-hot forms of the current winner and the held grant
  always_comb begin
    win_oh = '0;
    grant_oh = '0;
    win_oh[winner] = 1'b1;
    grant_oh[grant] = 1'b1;
  end

  assign req_ready = (state == IDLE && any_valid && !rst) ? win_oh : '0;
  assign resp_valid = (state == RESPOND) ? grant_oh : '0;
  assign resp_result = res_q;
  assign resp_flags = flags_q;
  assign unit_req_valid = (state == ISSUE);
  assign unit_resp_ready = (state == WAIT) || drain;
  assign unit_op = op_q;
  assign unit_a = a_q;
  assign unit_b = b_q;
  assign unit_mode = mode_q;
  assign busy = (state != IDLE);

  // Accept, issue, wait and respond; one operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      op_q <= DIV;
      a_q <= '0;
      b_q <= '0;
      mode_q <= FPU_RM_RNE;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= winner;
            op_q <= fpu_arb_op_t'(req_op[winner*3 +: 3]);
            a_q <= win_a;
            b_q <= win_b;
            mode_q <= fpu_round_mode_t'(req_mode[winner*2 +: 2]);
            if (is_nan(win_a) || is_nan(win_b)) begin
              res_q <= FPU_FLOAT_NAN;
              flags_q <= FPU_ARB_FLAGS_INVALID;
              state <= RESPOND;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (unit_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (unit_resp_valid && !drain) begin
            res_q <= unit_result;
            flags_q <= fpu_arb_flags_t'(unit_flags);
            state <= RESPOND;
          end else if (timed_out) begin
            res_q <= FPU_FLOAT_NAN;
            flags_q <= FPU_ARB_FLAGS_INVALID;
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (resp_ready[grant]) begin
            rr_ptr <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FPU_UNIT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (state == WAIT) && !unit_resp_valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, sticky error and late-response drain
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      drain <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (timed_out) begin
        timeout_err <= 1'b1;
        drain <= 1'b1;
      end else if (drain && unit_resp_valid) begin
        drain <= 1'b0;
      end
    end
  end
`else
  assign drain = 1'b0;
  assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// tb_fpu_unit_arbiter: random and directed checks of the arbiter.
// Transaction-level reference model plus a small unit emulator.
module tb_fpu_unit_arbiter;
  import fpu_pkg::*;
  import fpu_unit_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [N*3-1:0] req_op;
  logic [N*32-1:0] req_a, req_b;
  logic [N*2-1:0] req_mode;
  logic [31:0] resp_result;
  logic [4:0] resp_flags;
  logic unit_req_valid, unit_req_ready;
  logic [2:0] unit_op;
  logic [31:0] unit_a, unit_b;
  logic [1:0] unit_mode;
  logic unit_resp_valid, unit_resp_ready;
  logic [31:0] unit_result;
  logic [4:0] unit_flags;
  logic busy;
`ifdef FPU_UNIT_ARBITER_TIMEOUT_EN
  logic timeout_err;
`endif

  always #5 clk = ~clk;

  fpu_unit_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_mode(req_mode),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_result(resp_result),
    .resp_flags(resp_flags),
    .unit_req_valid(unit_req_valid),
    .unit_req_ready(unit_req_ready),
    .unit_op(unit_op),
    .unit_a(unit_a),
    .unit_b(unit_b),
    .unit_mode(unit_mode),
    .unit_resp_valid(unit_resp_valid),
    .unit_resp_ready(unit_resp_ready),
    .unit_result(unit_result),
    .unit_flags(unit_flags),
`ifdef FPU_UNIT_ARBITER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  int vecs = 0;
  int errs = 0;

  // model: one transaction record
  bit m_busy, m_nan, m_issued, m_done;
  int m_g, m_ptr;
  logic [2:0] m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [1:0] m_mode;
  logic [4:0] m_fl;

  // unit emulator
  bit u_pend;
  int u_cnt, u_delay;
  logic [31:0] u_res, u_next_res;
  logic [4:0] u_fl, u_next_fl;

  int grants[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] oh(int i);
    return 32'd1 << i;
  endfunction

  task automatic mreset();
    m_busy = 0;
    m_ptr = 0;
    m_done = 0;
    m_issued = 0;
    m_nan = 0;
    u_pend = 0;
    u_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = '0;
    unit_req_ready = 1'b0;
    unit_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mreset();
  endtask

  task automatic step();
    int w;
    bit iss_hs, rsp_hs;
    unit_resp_valid = u_pend && (u_cnt == 0);
    unit_result = u_res;
    unit_flags = u_fl;
    #1;
    w = pick(req_valid, m_ptr);
    chk("req_ready", req_ready, (!m_busy && w >= 0) ? oh(w) : 0);
    chk("unit_req_valid", unit_req_valid, m_busy && !m_done && !m_issued);
    chk("unit_resp_ready", unit_resp_ready, m_busy && m_issued && !m_done);
    chk("resp_valid", resp_valid, (m_busy && m_done) ? oh(m_g) : 0);
    chk("busy", busy, m_busy);
    if (m_busy && !m_done && !m_issued) begin
      chk("unit_op", unit_op, m_op);
      chk("unit_a", unit_a, m_a);
      chk("unit_b", unit_b, m_b);
      chk("unit_mode", unit_mode, m_mode);
    end
    if (m_busy && m_done) begin
      chk("resp_result", resp_result, m_res);
      chk("resp_flags", resp_flags, m_fl);
    end
    for (int k = 0; k < N; k++)
      if (req_ready[k]) grants.push_back(k);
    iss_hs = m_busy && !m_done && !m_issued && unit_req_ready;
    rsp_hs = m_busy && m_issued && !m_done && unit_resp_valid;
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1;
        m_g = w;
        m_op = req_op[w*3 +: 3];
        m_a = req_a[w*32 +: 32];
        m_b = req_b[w*32 +: 32];
        m_mode = req_mode[w*2 +: 2];
        m_nan = (m_a == 32'hFFFF_FFFF) || (m_b == 32'hFFFF_FFFF);
        m_issued = 0;
        m_done = m_nan;
        m_res = 32'hFFFF_FFFF;
        m_fl = 5'b10000;
      end
    end else if (!m_done) begin
      if (iss_hs) m_issued = 1;
      else if (rsp_hs) begin
        m_done = 1;
        m_res = unit_result;
        m_fl = unit_flags;
      end
    end else if (resp_ready[m_g]) begin
      m_busy = 0;
      m_ptr = (m_g + 1) % N;
    end
    if (iss_hs) begin
      u_pend = 1;
      u_cnt = u_delay;
      u_res = u_next_res;
      u_fl = u_next_fl;
    end else if (u_pend) begin
      if (u_cnt > 0) u_cnt--;
      else if (rsp_hs) u_pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    for (int k = 0; k < N; k++) begin
      req_op[k*3 +: 3] = 3'($urandom_range(0, 3));
      req_a[k*32 +: 32] = $urandom & 32'h7FFF_FFFF;
      req_b[k*32 +: 32] = $urandom & 32'h7FFF_FFFF;
      req_mode[k*2 +: 2] = 2'($urandom);
    end
  endtask

  task automatic rand_inputs();
    set_ops();
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 15) == 0) req_a[k*32 +: 32] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) req_b[k*32 +: 32] = 32'hFFFF_FFFF;
    end
    req_valid = N'($urandom);
    resp_ready = N'($urandom);
    unit_req_ready = ($urandom_range(0, 2) != 0);
    u_delay = $urandom_range(0, 6);
    u_next_res = $urandom;
    u_next_fl = 5'($urandom);
  endtask

  task automatic drain_all();
    int n;
    req_valid = '0;
    resp_ready = '1;
    unit_req_ready = 1'b1;
    n = 0;
    while (m_busy && n < 100) begin
      step();
      n++;
    end
    chk("drain_idle", m_busy, 0);
  endtask

  task automatic run_grants(int target);
    int n;
    n = 0;
    while (grants.size() < target && n < 200) begin
      u_delay = $urandom_range(0, 3);
      u_next_res = $urandom;
      step();
      n++;
    end
    chk("grant_budget", grants.size(), target);
  endtask

  initial begin
    int lat;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    req_mode = '0;
    unit_result = '0;
    unit_flags = '0;
    u_delay = 0;
    u_next_res = '0;
    u_next_fl = '0;
    u_res = '0;
    u_fl = '0;
    do_reset();

    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_unit_req_valid", unit_req_valid, 0);
    chk("rst_unit_resp_ready", unit_resp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_b", unit_b, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_flags", resp_flags, 0);

    // single request, unit answers 5 cycles into WAIT
    set_ops();
    req_op[2:0] = 3'd0;
    req_a[31:0] = 32'h4040_0000;
    req_b[31:0] = 32'h3F80_0000;
    req_valid = 4'b0001;
    resp_ready = 4'b1111;
    unit_req_ready = 1'b1;
    u_delay = 5;
    u_next_res = 32'h4040_0000;
    u_next_fl = 5'b0;
    step();
    req_valid = '0;
    lat = 1;
    while (resp_valid != 4'b0001 && lat < 20) begin
      step();
      lat++;
    end
    chk("single_latency", lat, 8);
    chk("single_result", resp_result, 32'h4040_0000);
    chk("single_flags", resp_flags, 0);
    drain_all();

    // fairness with all requesting
    do_reset();
    set_ops();
    req_valid = 4'b1111;
    resp_ready = 4'b1111;
    unit_req_ready = 1'b1;
    grants.delete();
    run_grants(8);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      chk($sformatf("fair_grant%0d", k), grants[k], k % 4);
    drain_all();

    // pointer wrap: grant 2 moves pointer to 3, then 1001
    grants.delete();
    req_valid = 4'b0100;
    run_grants(1);
    req_valid = 4'b1001;
    run_grants(3);
    if (grants.size() == 3) begin
      chk("wrap_first", grants[1], 3);
      chk("wrap_second", grants[2], 0);
    end
    drain_all();

    // backpressure on issue and on response
    set_ops();
    req_valid = 4'b0010;
    unit_req_ready = 1'b0;
    step();
    req_valid = '0;
    repeat (4) step();
    chk("bp_issue_held", unit_req_valid, 1);
    unit_req_ready = 1'b1;
    resp_ready = '0;
    u_delay = 0;
    u_next_res = 32'h1234_5678;
    u_next_fl = 5'b00001;
    step();
    step();
    req_valid = 4'b1111;
    repeat (3) begin
      step();
      chk("bp_no_ready", req_ready, 0);
      chk("bp_result", resp_result, 32'h1234_5678);
    end
    drain_all();

    // NaN short-circuit
    set_ops();
    req_a[31:0] = 32'hFFFF_FFFF;
    req_valid = 4'b0001;
    resp_ready = '0;
    step();
    req_valid = '0;
    chk("nan_resp_valid", resp_valid, 4'b0001);
    chk("nan_result", resp_result, 32'hFFFF_FFFF);
    chk("nan_flags", resp_flags, 5'b10000);
    chk("nan_no_issue", unit_req_valid, 0);
    drain_all();

    // reset while waiting on the unit
    set_ops();
    req_valid = 4'b0100;
    unit_req_ready = 1'b1;
    u_delay = 50;
    step();
    req_valid = '0;
    step();
    chk("wait_resp_ready", unit_resp_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mreset();
    unit_resp_valid = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_unit_req_valid", unit_req_valid, 0);
    chk("rw_unit_resp_ready", unit_resp_ready, 0);
    chk("rw_unit_a", unit_a, 0);
    repeat (10) step();

    // random traffic
    repeat (1500) begin
      rand_inputs();
      step();
    end
    drain_all();

`ifdef FPU_UNIT_ARBITER_TIMEOUT_EN
    do_reset();
    chk("to_err_reset", timeout_err, 0);
    set_ops();
    req_valid = 4'b0001;
    unit_req_ready = 1'b1;
    resp_ready = '1;
    @(posedge clk);
    #1 req_valid = '0;
    lat = 0;
    while (resp_valid == '0 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("to_resp_valid", resp_valid, 4'b0001);
    chk("to_result", resp_result, 32'hFFFF_FFFF);
    chk("to_flags", resp_flags, 5'b10000);
    chk("to_err", timeout_err, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
